dac_sample_unpacker: RTL
========================

// Module: dac_sample_unpacker
// PURPOSE
//  Playback-side counterpart of the ADC capture path. Reads 32-bit host words from a
//  standard (non-FWFT) FIFO filled by the host write stream and splits each word into
//  two 16-bit DAC samples. Presents one sample per RATE_DIV clocks to the DAC interface.
//  Flags underrun when a sample slot finds no data.
// PARAMETERS
//  DIN_W      32  FIFO word width; must equal 2*SAMPLE_W
//  SAMPLE_W   16  DAC sample width
//  RATE_DIV   8   clocks per sample slot; legal range >= 4
//  LOW_FIRST  1   1: bits[15:0] are output before [31:16]; 0: [31:16] first
// PORTS
//  clk          in   1         single clock for the whole block
//  rst          in   1         synchronous, active-high reset
//  enable       in   1         run playback; low freezes the slot counter and fetches
//  clr_underrun in   1         one-cycle pulse that clears underrun
//  fifo_empty   in   1         FIFO empty flag
//  fifo_dout    in   DIN_W     FIFO read data; valid the cycle after fifo_rd_en
//  fifo_rd_en   out  1         registered; one-cycle pulse per word fetched
//  dac_data     out  SAMPLE_W  current DAC sample; held between updates
//  dac_valid    out  1         one-cycle pulse when dac_data takes a new value
//  underrun     out  1         sticky: a slot occurred with no sample buffered
//  sample_count out  32        samples output since reset; wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: all outputs 0, state EMPTY, slot counter 0, half index 0, word register 0.
//  Slot counter: counts 0..RATE_DIV-1 while enable=1. tick = (cnt==RATE_DIV-1).
//    enable=0 holds cnt at 0, so the first tick comes RATE_DIV cycles after enable rises.
//  FSM (word buffer, one word deep):
//   EMPTY: if enable & !fifo_empty, fifo_rd_en<=1, go FETCH.
//   FETCH: fifo_rd_en<=0. Capture fifo_dout into the word register. half<=0. Go FULL.
//          Capture happens even if enable has dropped.
//   FULL : on tick, output the selected half.
//          half=0 -> half<=1, stay in FULL.
//          half=1 -> go EMPTY.
//  Half select: LOW_FIRST=1 gives half0=[15:0], half1=[31:16]; LOW_FIRST=0 swaps them.
//  Output latency: dac_data, dac_valid and sample_count+1 all update on the clock edge
//    that ends the tick cycle.
//  Refill timing: from entering EMPTY, the word is FULL 3 cycles later. RATE_DIV>=4
//    therefore guarantees no underrun while the FIFO has data.
//  Underrun: a tick in EMPTY or FETCH sets underrun<=1.
//    No dac_valid pulse; dac_data keeps its last value; sample_count is unchanged.
//    A tick in FETCH is an underrun even though data arrives that cycle.
//  clr_underrun clears the flag. If clr_underrun coincides with a new underrun, set wins.
//  enable=0 in FULL: the buffered word and half index are retained, and playback resumes
//    at the same half.
//  rst mid-operation: any in-flight FIFO word (rd_en already issued) is discarded.
//    This is an accepted loss, and software restarts the stream after reset.
//  fifo_rd_en is never asserted while fifo_empty=1 (it is qualified in EMPTY only).
// STRUCTURE
//  Shared package dac_pkg: state encoding (EMPTY/FETCH/FULL) and SAMPLE_W/DIN_W defaults.
//  One sub-module: dac_rate_tick (clk, rst, enable -> tick), the RATE_DIV slot counter.
//    It is reusable for the ADC-side decimation strobe.
//  Word buffer, FSM and output registers stay in this module.
// TESTING
//  1. rst=1 for 2 clocks with FIFO non-empty -> all outputs 0, fifo_rd_en stays 0.
//  2. FIFO holds 0x22221111 and 0x44443333; RATE_DIV=8, LOW_FIRST=1, enable=1
//     -> dac_data 0x1111, 0x2222, 0x3333, 0x4444.
//     -> dac_valid pulses 8 clocks apart, exactly 2 fifo_rd_en pulses,
//        sample_count=4, underrun=0.
//  3. Continue case 2 with the FIFO now empty -> next tick sets underrun=1.
//     -> dac_data stays 0x4444, no dac_valid pulse, sample_count stays 4.
//     -> clr_underrun pulse gives underrun=0; clr_underrun coincident with a tick -> stays 1.
//  4. LOW_FIRST=0 with word 0xBEEF0001 -> outputs 0xBEEF then 0x0001.
//  5. Drop enable after first half (0x1111) for 20 clocks, then re-enable
//     -> no dac_valid while disabled, no extra fifo_rd_en.
//     -> next output is 0x2222 exactly 8 clocks after enable rises.
//  6. Assert rst the cycle fifo_rd_en=1 -> next cycle rd_en=0 and state EMPTY.
//     -> after release the next word is fetched fresh; the in-flight word never
//        appears on dac_data.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC playback path: word-buffer state encoding
// and default sample/word widths.
package dac_pkg;

  localparam int unsigned SAMPLE_W_DEF = 16;
  localparam int unsigned DIN_W_DEF    = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/dac_rate_tick.sv
// Slot strobe generator: counts 0..RATE_DIV-1 while enabled and flags the
// last count. Held at 0 while disabled, so the first strobe lands RATE_DIV
// cycles after enable rises. Also usable as the ADC decimation strobe.
module dac_rate_tick #(
  parameter int unsigned RATE_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned  CW   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATE_DIV - 1);

  logic [CW-1:0] cnt;

  // Slot counter, frozen at zero while playback is disabled
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/dac_sample_unpacker.sv
// Playback unpacker: fetches 32-bit words from a standard FIFO and plays
// them out as two DAC samples, one per slot, flagging slots with no data.
module dac_sample_unpacker
  import dac_pkg::*;
#(
  parameter int unsigned DIN_W     = DIN_W_DEF,
  parameter int unsigned SAMPLE_W  = SAMPLE_W_DEF,
  parameter int unsigned RATE_DIV  = 8,
  parameter bit          LOW_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clr_underrun,
  input  logic                fifo_empty,
  input  logic [DIN_W-1:0]    fifo_dout,
  output logic                fifo_rd_en,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic                dac_valid,
  output logic                underrun,
  output logic [31:0]         sample_count
);

  if (DIN_W != 2 * SAMPLE_W) begin : g_bad_width
    $error("dac_sample_unpacker: DIN_W must equal 2*SAMPLE_W");
  end
  if (RATE_DIV < 4) begin : g_bad_rate
    $error("dac_sample_unpacker: RATE_DIV must be at least 4");
  end

  state_t             state;
  logic               fetch_wait;
  logic               half;
  logic [DIN_W-1:0]   word;
  logic               tick;
  logic [SAMPLE_W-1:0] half0;
  logic [SAMPLE_W-1:0] half1;

  dac_rate_tick #(
    .RATE_DIV (RATE_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // Map buffer halves to playback order
  always_comb begin
    half0 = word[SAMPLE_W-1:0];
    half1 = word[DIN_W-1:SAMPLE_W];
    if (!LOW_FIRST) begin
      half0 = word[DIN_W-1:SAMPLE_W];
      half1 = word[SAMPLE_W-1:0];
    end
  end

  // Word buffer FSM with registered FIFO strobe, DAC outputs and underrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      fetch_wait   <= 1'b0;
      half         <= 1'b0;
      word         <= '0;
      fifo_rd_en   <= 1'b0;
      dac_data     <= '0;
      dac_valid    <= 1'b0;
      underrun     <= 1'b0;
      sample_count <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      dac_valid  <= 1'b0;
      // Clear first so a coincident underrun below takes priority
      if (clr_underrun) begin
        underrun <= 1'b0;
      end
      unique case (state)
        ST_EMPTY: begin
          if (tick) begin
            underrun <= 1'b1;
          end
          if (enable && !fifo_empty) begin
            fifo_rd_en <= 1'b1;
            fetch_wait <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (tick) begin
            underrun <= 1'b1;
          end
          // The registered strobe reaches the FIFO one edge after it is
          // raised, so read data lands a cycle later: FETCH spans two
          // cycles and captures on the second (FULL three cycles after EMPTY).
          if (fetch_wait) begin
            fetch_wait <= 1'b0;
          end else begin
            word  <= fifo_dout;
            half  <= 1'b0;
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (tick) begin
            dac_data     <= half ? half1 : half0;
            dac_valid    <= 1'b1;
            sample_count <= sample_count + 32'd1;
            if (half) begin
              state <= ST_EMPTY;
            end else begin
              half <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule
